// File: rtl/processor_run_pkg.sv
// Shared types and default sizing for the Processor run controller and the Processor top.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package processor_run_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 16;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUN,
        CHECK,
        DONE
    } run_state_t;

endpackage

// File: rtl/processor_run_ctrl_if.sv
// Host-side control/status bundle of the run controller.
// Latency: none (wires only).
// Backpressure: none; start is a pulse, status is level/pulse.
// master = host (drives start and expected values), slave = processor_run_ctrl.
// RUN_CTRL_SNAPSHOT_EN adds fail_val, the captured value of the first failing register.
interface processor_run_ctrl_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 32
);
    logic                         start;
    logic [NUM_REGS*DATA_W-1:0]   expect_flat;
    logic [NUM_REGS-1:0]          expect_mask;
    logic [CNT_W-1:0]             cycle_count;
    logic                         busy;
    logic                         done;
    logic                         pass;
    logic                         timeout;
    logic [$clog2(NUM_REGS)-1:0]  fail_idx;
`ifdef RUN_CTRL_SNAPSHOT_EN
    logic [DATA_W-1:0]            fail_val;

    modport master (output start, expect_flat, expect_mask,
                    input  cycle_count, busy, done, pass, timeout, fail_idx, fail_val);
    modport slave  (input  start, expect_flat, expect_mask,
                    output cycle_count, busy, done, pass, timeout, fail_idx, fail_val);
`else
    modport master (output start, expect_flat, expect_mask,
                    input  cycle_count, busy, done, pass, timeout, fail_idx);
    modport slave  (input  start, expect_flat, expect_mask,
                    output cycle_count, busy, done, pass, timeout, fail_idx);
`endif
endinterface

// File: rtl/reg_stable_det.sv
// Halt detector: flags when the watched register bus has been unchanged for STABLE_CYCLES samples.
// Latency: combinational stable in the sample cycle that completes the quiet streak.
// Backpressure: none; sample qualifies each cycle, clr re-arms so the next sample counts as a change.
// Ports: clk, rst (async active-low), clr, sample, regs_flat in; stable out.
module reg_stable_det
    import processor_run_pkg::*;
#(
    parameter int W             = DEF_DATA_W * DEF_NUM_REGS,
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         sample,
    input  logic [W-1:0] regs_flat,
    output logic         stable
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);

    logic [W-1:0]  prev;
    logic [SW-1:0] cnt_q;
    logic [SW-1:0] cnt_nxt;
    logic          primed;   // prev holds a real sample; first sample after clr is a change

    // cnt_nxt is the streak length including the current cycle.
    always_comb begin
        cnt_nxt = '0;
        if (primed && (regs_flat == prev)) begin
            if (cnt_q == SW'(STABLE_CYCLES)) cnt_nxt = cnt_q;
            else                              cnt_nxt = cnt_q + 1'b1;
        end
        stable = sample && (cnt_nxt == SW'(STABLE_CYCLES));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev   <= '0;
            cnt_q  <= '0;
            primed <= 1'b0;
        end else if (clr) begin
            cnt_q  <= '0;
            primed <= 1'b0;
        end else if (sample) begin
            prev   <= regs_flat;
            cnt_q  <= cnt_nxt;
            primed <= 1'b1;
        end
    end
endmodule

// File: rtl/processor_run_ctrl.sv
// Run controller: resets the core, runs it until halt or cycle limit, then checks registers one per cycle.
// Latency: start to first RUN cycle 1+RST_CYCLES; last register change to done STABLE_CYCLES+NUM_REGS+1.
// Backpressure: none; start is accepted only in IDLE and ignored otherwise.
// Ports: clk, rst (async active-low), core_rst out, regs_flat in, bus (slave: start/expect in, status out).
// Optional macro RUN_CTRL_SNAPSHOT_EN: adds bus.fail_val, the value of register fail_idx at the mismatch.
module processor_run_ctrl
    import processor_run_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int NUM_REGS      = DEF_NUM_REGS,
    parameter int RST_CYCLES    = 1,
    parameter int STABLE_CYCLES = 4,
    parameter int MAX_CYCLES    = 1000,
    parameter int CNT_W         = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       core_rst,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    processor_run_ctrl_if.slave        bus
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int RCW   = $clog2(RST_CYCLES + 1);

    run_state_t        state, state_nxt;
    logic [RCW-1:0]    rst_cnt;
    logic [IDX_W-1:0]  idx;
    logic              mis_seen;
    logic              stable;
    logic [CNT_W-1:0]  cycle_count_q, cc_inc;
    logic              pass_q, timeout_q;
    logic [IDX_W-1:0]  fail_idx_q;
    logic [DATA_W-1:0] cur_act, cur_exp;
    logic              cur_mis, last_idx, rst_last, timeout_hit;

    reg_stable_det #(
        .W             (NUM_REGS * DATA_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stable (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == RESET),
        .sample    (state == RUN),
        .regs_flat (regs_flat),
        .stable    (stable)
    );

    assign cc_inc      = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;
    // Limit is judged on the count including the current RUN cycle.
    assign timeout_hit = (cc_inc == CNT_W'(MAX_CYCLES));
    assign rst_last    = (rst_cnt == RCW'(RST_CYCLES - 1));
    assign last_idx    = (idx == IDX_W'(NUM_REGS - 1));
    assign cur_act     = regs_flat[idx*DATA_W +: DATA_W];
    assign cur_exp     = bus.expect_flat[idx*DATA_W +: DATA_W];
    assign cur_mis     = bus.expect_mask[idx] && (cur_act != cur_exp);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        core_rst  = 1'b1;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_nxt = RESET;
            RESET: begin
                bus.busy = 1'b1;
                if (rst_last) state_nxt = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                core_rst = 1'b0;
                // Halt takes priority over the cycle limit.
                if (stable)           state_nxt = CHECK;
                else if (timeout_hit) state_nxt = DONE;
            end
            CHECK: begin
                bus.busy = 1'b1;
                core_rst = 1'b0;
                if (last_idx) state_nxt = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef RUN_CTRL_SNAPSHOT_EN
    logic [DATA_W-1:0] fail_val_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                 fail_val_q <= '0;
        else if (state == IDLE && bus.start)      fail_val_q <= '0;
        else if (state == CHECK && cur_mis && !mis_seen) fail_val_q <= cur_act;
    end
    assign bus.fail_val = fail_val_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count_q <= '0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            fail_idx_q    <= '0;
            mis_seen      <= 1'b0;
            idx           <= '0;
            rst_cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    cycle_count_q <= '0;
                    pass_q        <= 1'b0;
                    timeout_q     <= 1'b0;
                    fail_idx_q    <= '0;
                    mis_seen      <= 1'b0;
                    idx           <= '0;
                    rst_cnt       <= '0;
                end
                RESET: rst_cnt <= rst_cnt + 1'b1;
                RUN: begin
                    cycle_count_q <= cc_inc;
                    if (!stable && timeout_hit) begin
                        timeout_q <= 1'b1;
                        pass_q    <= 1'b0;
                    end
                end
                CHECK: begin
                    idx <= idx + 1'b1;
                    if (cur_mis && !mis_seen) begin
                        mis_seen   <= 1'b1;
                        fail_idx_q <= idx;
                    end
                    if (last_idx) pass_q <= !(mis_seen || cur_mis);
                end
                default: ;
            endcase
        end
    end

    assign bus.cycle_count = cycle_count_q;
    assign bus.pass        = pass_q;
    assign bus.timeout     = timeout_q;
    assign bus.fail_idx    = fail_idx_q;
endmodule
